// File: rtl/rsnn_pkg.sv
// Shared RSNN constants and the parameter-loader state encoding.
// Weights occupy the upper RSNN_WEIGHT_BITS of the parameter word; neuron params sit below.
package rsnn_pkg;

    localparam int unsigned RSNN_PARAM_BITS        = 312;
    localparam int unsigned RSNN_WEIGHT_BITS       = 216;
    localparam int unsigned RSNN_NEURON_PARAM_BITS = 96;
    localparam int unsigned RSNN_WEIGHT_LSB        = 96;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } loader_state_t;

endpackage

// File: rtl/rsnn_sync_chain.sv
// Reset-to-zero flop chain used to bring asynchronous control pins into the clk domain.
module rsnn_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rsnn_param_loader.sv
// Serial parameter loader: shifts a bitstream into a shadow word, optionally checks an
// even-parity trailer, and commits the whole word to params in a single edge.
module rsnn_param_loader
    import rsnn_pkg::*;
#(
    parameter int unsigned TOTAL_BITS  = RSNN_PARAM_BITS,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PARITY_EN   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  system_enable,
    input  logic                  load_params,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [TOTAL_BITS-1:0] params,
    output logic                  params_valid,
    output logic                  busy,
    output logic                  data_written,
    output logic                  end_writing,
    output logic                  parity_error
);

    localparam int unsigned      CNT_W    = $clog2(TOTAL_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BITS - 1);

    loader_state_t         state;
    logic [CNT_W-1:0]      cnt;
    logic [TOTAL_BITS-1:0] shadow;
    logic [TOTAL_BITS-1:0] shifted;
    logic                  sen;
    logic                  lreq;
    logic                  lreq_d;
    logic                  lrise;
    logic                  accept;

    rsnn_sync_chain #(.STAGES(SYNC_STAGES)) u_sen_sync (
        .clk   (clk),
        .reset (reset),
        .d     (system_enable),
        .q     (sen)
    );

    rsnn_sync_chain #(.STAGES(SYNC_STAGES)) u_load_sync (
        .clk   (clk),
        .reset (reset),
        .d     (load_params),
        .q     (lreq)
    );

    assign lrise   = lreq & ~lreq_d;
    assign accept  = (state != IDLE) && sen && serial_valid;
    assign shifted = {shadow[TOTAL_BITS-2:0], serial_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow       <= '0;
            lreq_d       <= 1'b0;
            params       <= '0;
            params_valid <= 1'b0;
            busy         <= 1'b0;
            data_written <= 1'b0;
            end_writing  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            lreq_d       <= lreq;
            data_written <= 1'b0;
            end_writing  <= 1'b0;

            // A load request restarts from bit 0 in any busy state; from IDLE it needs sen.
            if (lrise && ((state != IDLE) || sen)) begin
                state        <= SHIFT;
                busy         <= 1'b1;
                cnt          <= '0;
                shadow       <= '0;
                parity_error <= 1'b0;
            end else if (accept) begin
                data_written <= 1'b1;
                if (state == SHIFT) begin
                    shadow <= shifted;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            state <= PARITY;
                        end else begin
                            state        <= IDLE;
                            busy         <= 1'b0;
                            params       <= shifted;
                            params_valid <= 1'b1;
                            end_writing  <= 1'b1;
                        end
                    end
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if ((^shadow) ^ serial_in) begin
                        parity_error <= 1'b1;
                    end else begin
                        params       <= shadow;
                        params_valid <= 1'b1;
                        end_writing  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rsnn_param_loader.sv
// Scoreboard bench for rsnn_param_loader: two 8-bit instances (with/without parity)
// and one default 312-bit instance share data pins but have separate load requests.
module tb_rsnn_param_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         system_enable;
    logic         lp_a, lp_b, lp_c;
    logic         serial_in;
    logic         serial_valid;

    logic [7:0]   params_a;
    logic         pv_a, busy_a, dw_a, ew_a, pe_a;
    logic [7:0]   params_b;
    logic         pv_b, busy_b, dw_b, ew_b, pe_b;
    logic [311:0] params_c;
    logic         pv_c, busy_c, dw_c, ew_c, pe_c;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           dw_cnt_a = 0, dw_cnt_b = 0, dw_cnt_c = 0;
    int           ew_cnt_a = 0, ew_cnt_b = 0, ew_cnt_c = 0;
    int           cyc_count = 0;
    int           t0 = 0;
    logic [1:0]   sen_pipe;
    logic [319:0] stream;
    logic [311:0] q_a[$];
    logic [311:0] q_b[$];
    logic [311:0] q_c[$];

    always #5 clk = ~clk;

    rsnn_param_loader #(.TOTAL_BITS(8), .SYNC_STAGES(2), .PARITY_EN(0)) dut_a (
        .clk(clk), .reset(reset), .system_enable(system_enable), .load_params(lp_a),
        .serial_in(serial_in), .serial_valid(serial_valid), .params(params_a),
        .params_valid(pv_a), .busy(busy_a), .data_written(dw_a), .end_writing(ew_a),
        .parity_error(pe_a)
    );

    rsnn_param_loader #(.TOTAL_BITS(8), .SYNC_STAGES(2), .PARITY_EN(1)) dut_b (
        .clk(clk), .reset(reset), .system_enable(system_enable), .load_params(lp_b),
        .serial_in(serial_in), .serial_valid(serial_valid), .params(params_b),
        .params_valid(pv_b), .busy(busy_b), .data_written(dw_b), .end_writing(ew_b),
        .parity_error(pe_b)
    );

    rsnn_param_loader dut_c (
        .clk(clk), .reset(reset), .system_enable(system_enable), .load_params(lp_c),
        .serial_in(serial_in), .serial_valid(serial_valid), .params(params_c),
        .params_valid(pv_c), .busy(busy_c), .data_written(dw_c), .end_writing(ew_c),
        .parity_error(pe_c)
    );

    // Expected view of the synchronised enable, used to predict bit acceptance.
    always @(posedge clk or posedge reset) begin
        if (reset) sen_pipe <= 2'b00;
        else       sen_pipe <= {sen_pipe[0], system_enable};
    end

    always @(posedge clk) cyc_count <= cyc_count + 1;

    always @(negedge clk) begin : monitor
        logic [311:0] e;
        if (!reset) begin
            if (dw_a) dw_cnt_a++;
            if (dw_b) dw_cnt_b++;
            if (dw_c) dw_cnt_c++;
            if (ew_a) begin
                ew_cnt_a++;
                n_checks++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a_unexpected: commit with nothing expected, params=%h", params_a);
                end else begin
                    e = q_a.pop_front();
                    if (params_a !== e[7:0] || pv_a !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_a_params: got %h valid=%b, expected %h valid=1", params_a, pv_a, e[7:0]);
                    end
                end
            end
            if (ew_b) begin
                ew_cnt_b++;
                n_checks++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b_unexpected: commit with nothing expected, params=%h", params_b);
                end else begin
                    e = q_b.pop_front();
                    if (params_b !== e[7:0] || pv_b !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_b_params: got %h valid=%b, expected %h valid=1", params_b, pv_b, e[7:0]);
                    end
                end
            end
            if (ew_c) begin
                ew_cnt_c++;
                n_checks++;
                if (q_c.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_c_unexpected: commit with nothing expected");
                end else begin
                    e = q_c.pop_front();
                    if (params_c !== e || pv_c !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_c_params: got %h valid=%b, expected %h", params_c, pv_c, e);
                    end
                end
            end
        end
    end

    function automatic logic get_dw(input int w);
        case (w)
            0:       return dw_a;
            1:       return dw_b;
            default: return dw_c;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic set_lp(input int w, input logic v);
        case (w)
            0:       lp_a = v;
            1:       lp_b = v;
            default: lp_c = v;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after edge k+2, where busy must be high.
    task automatic do_load(input int w, input bit from_idle);
        serial_valid = 1'b0;
        set_lp(w, 1'b1);
        t0 = cyc_count + 1;
        @(negedge clk);
        set_lp(w, 1'b0);
        @(negedge clk);
        if (from_idle) begin
            n_checks++;
            if (get_busy(w) !== 1'b0) begin
                n_fail++;
                $display("FAIL load_busy_early: dut %0d busy=%b, expected 0", w, get_busy(w));
            end
        end
        @(negedge clk);
        n_checks++;
        if (get_busy(w) !== 1'b1) begin
            n_fail++;
            $display("FAIL load_busy: dut %0d busy=%b, expected 1", w, get_busy(w));
        end
    endtask

    // Sends stream[nbits-1:0] MSB first; returns at the negedge after the last accepting edge.
    task automatic drive_bits(input int w, input int nbits, input bit rnd, input int drop_after);
        int i = 0;
        int cyc = 0;
        int low_left = 0;
        bit dropped = 1'b0;
        logic exp_dw;
        while (i < nbits && cyc < 2000) begin
            if (drop_after >= 0 && !dropped && i == drop_after) begin
                system_enable = 1'b0;
                low_left = 5;
                dropped = 1'b1;
            end else if (low_left > 0) begin
                low_left--;
                if (low_left == 0) system_enable = 1'b1;
            end
            serial_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            serial_in    = serial_valid ? stream[nbits-1-i] : 1'($urandom_range(0, 1));
            exp_dw = serial_valid && sen_pipe[1];
            if (exp_dw) i++;
            @(negedge clk);
            n_checks++;
            if (get_dw(w) !== exp_dw) begin
                n_fail++;
                $display("FAIL data_written: dut %0d bit %0d got %b, expected %b", w, i, get_dw(w), exp_dw);
            end
            cyc++;
        end
        serial_valid  = 1'b0;
        system_enable = 1'b1;
        if (i < nbits) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout: dut %0d accepted %0d of %0d bits", w, i, nbits);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; system_enable = 1'b1; lp_a = 0; lp_b = 0; lp_c = 0;
        serial_in = 0; serial_valid = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({params_a, pv_a, busy_a, dw_a, ew_a, pe_a} !== '0 ||
            {params_b, pv_b, busy_b, dw_b, ew_b, pe_b} !== '0 ||
            {params_c, pv_c, busy_c, dw_c, ew_c, pe_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: a=%h/%b%b b=%h/%b%b c_valid=%b, expected all 0",
                     params_a, pv_a, busy_a, params_b, pv_b, busy_b, pv_c);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_no_parity;
        int dw0 = dw_cnt_a;
        int ew0 = ew_cnt_a;
        stream = '0;
        stream[7:0] = 8'b1011_0010;
        q_a.push_back(312'h0B2);
        do_load(0, 1'b1);
        drive_bits(0, 8, 1'b0, -1);
        n_checks++;
        if (ew_a !== 1'b1 || busy_a !== 1'b0 || pv_a !== 1'b1) begin
            n_fail++;
            $display("FAIL nopar_commit_edge: ew=%b busy=%b valid=%b, expected 1 0 1", ew_a, busy_a, pv_a);
        end
        @(negedge clk);
        n_checks++;
        if (ew_a !== 1'b0 || dw_cnt_a - dw0 != 8 || ew_cnt_a - ew0 != 1 || params_a !== 8'hB2) begin
            n_fail++;
            $display("FAIL nopar_counts: ew=%b dw=%0d ew_n=%0d params=%h, expected 0 8 1 b2",
                     ew_a, dw_cnt_a - dw0, ew_cnt_a - ew0, params_a);
        end
    endtask

    task automatic test_parity;
        int ew0;
        stream = '0;
        stream[8:0] = {8'hB2, 1'b0};
        q_b.push_back(312'h0B2);
        do_load(1, 1'b1);
        drive_bits(1, 9, 1'b0, -1);
        n_checks++;
        if (ew_b !== 1'b1 || pe_b !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_ok: ew=%b perr=%b, expected 1 0", ew_b, pe_b);
        end
        @(negedge clk);
        ew0 = ew_cnt_b;
        stream[8:0] = {8'h00, 1'b1};
        do_load(1, 1'b1);
        drive_bits(1, 9, 1'b0, -1);
        n_checks++;
        if (pe_b !== 1'b1 || params_b !== 8'hB2 || pv_b !== 1'b1 || busy_b !== 1'b0 || ew_b !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_bad: perr=%b params=%h valid=%b busy=%b ew=%b, expected 1 b2 1 0 0",
                     pe_b, params_b, pv_b, busy_b, ew_b);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (pe_b !== 1'b1 || ew_cnt_b != ew0) begin
            n_fail++;
            $display("FAIL parity_sticky: perr=%b commits=%0d, expected 1 0", pe_b, ew_cnt_b - ew0);
        end
    endtask

    task automatic test_stall;
        int dw0 = dw_cnt_b;
        stream = '0;
        stream[8:0] = {8'h5A, 1'b0};
        q_b.push_back(312'h05A);
        do_load(1, 1'b1);
        n_checks++;
        if (pe_b !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_perr_clear: perr=%b, expected 0", pe_b);
        end
        drive_bits(1, 9, 1'b1, 3);
        @(negedge clk);
        n_checks++;
        if (params_b !== 8'h5A || dw_cnt_b - dw0 != 9) begin
            n_fail++;
            $display("FAIL stall_result: params=%h bits=%0d, expected 5a 9", params_b, dw_cnt_b - dw0);
        end
    endtask

    task automatic test_restart;
        stream = '0;
        stream[3:0] = 4'hF;
        do_load(1, 1'b1);
        drive_bits(1, 4, 1'b0, -1);
        do_load(1, 1'b0);
        n_checks++;
        if (params_b !== 8'h5A || pv_b !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_hold: params=%h valid=%b, expected 5a 1", params_b, pv_b);
        end
        stream[8:0] = {8'h3C, 1'b0};
        q_b.push_back(312'h03C);
        drive_bits(1, 9, 1'b0, -1);
        @(negedge clk);
        n_checks++;
        if (params_b !== 8'h3C) begin
            n_fail++;
            $display("FAIL restart_result: params=%h, expected 3c", params_b);
        end
    endtask

    task automatic test_reset_midload;
        stream = '0;
        stream[4:0] = 5'b10101;
        do_load(1, 1'b1);
        drive_bits(1, 5, 1'b0, -1);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({params_b, pv_b, busy_b, dw_b, ew_b, pe_b} !== '0 || params_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midload: params=%h valid=%b busy=%b dw=%b, expected all 0",
                     params_b, pv_b, busy_b, dw_b);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        stream[8:0] = {8'hC3, 1'b0};
        q_b.push_back(312'h0C3);
        do_load(1, 1'b1);
        drive_bits(1, 9, 1'b0, -1);
        n_checks++;
        if (pv_b !== 1'b1 || ew_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_after_reset: valid=%b ew=%b, expected 1 1", pv_b, ew_b);
        end
        @(negedge clk);
    endtask

    task automatic test_full_width;
        logic [319:0] r;
        logic [311:0] data;
        int latency;
        for (int j = 0; j < 10; j++) r[j*32 +: 32] = $urandom();
        data = r[311:0];
        stream = '0;
        stream[312:0] = {data, ^data};
        q_c.push_back(data);
        do_load(2, 1'b1);
        drive_bits(2, 313, 1'b0, -1);
        latency = cyc_count - t0 + 1;
        n_checks++;
        if (ew_c !== 1'b1 || latency != 2 + 1 + 313) begin
            n_fail++;
            $display("FAIL full_latency: ew=%b cycles=%0d, expected 1 316", ew_c, latency);
        end
        n_checks++;
        if (params_c[311:96] !== data[311:96]) begin
            n_fail++;
            $display("FAIL full_weights: got %h, expected %h", params_c[311:96], data[311:96]);
        end
        n_checks++;
        if (params_c[95:0] !== data[95:0] || pe_c !== 1'b0) begin
            n_fail++;
            $display("FAIL full_neuron: got %h perr=%b, expected %h perr=0", params_c[95:0], pe_c, data[95:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_stall();
        test_restart();
        test_reset_midload();
        test_full_width();
        repeat (2) @(negedge clk);
        n_checks++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected commits never seen, expected 0",
                     q_a.size() + q_b.size() + q_c.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rsnn_param_loader.md
# rsnn_param_loader

Parametrised serial parameter loader for the RSNN: synchronises the asynchronous `system_enable` and `load_params` controls, shifts a serial bitstream into a shadow register, optionally checks an even-parity trailer bit, and commits the word atomically to a parallel output. The network therefore always sees a complete, validated parameter set, even while a reload is in progress. It replaces the fixed 312-bit FIPO memory and memory control unit pair between the chip pins and `ThreeLayerNeuralNetwork`.

## Interface
- `TOTAL_BITS`, 312, number of payload bits: weights occupy [311:96], neuron params occupy [95:0].
- `SYNC_STAGES`, 2, flop count per synchroniser chain; minimum 2.
- `PARITY_EN`, 1, 1 = one even-parity bit follows the payload; 0 = no trailer.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `system_enable`  in  1  async global enable; synchronised internally.
- `load_params`  in  1  async load request; its synchronised rising edge starts a load.
- `serial_in`  in  1  serial data, MSB first, synchronous to `clk`.
- `serial_valid`  in  1  qualifies `serial_in` for the current cycle.
- `params`  out  TOTAL_BITS  committed parameter word.
- `params_valid`  out  1  level; set after the first successful commit.
- `busy`  out  1  high whenever state ≠ IDLE.
- `data_written`  out  1  one-cycle pulse per accepted bit, payload or parity.
- `end_writing`  out  1  one-cycle pulse on a successful commit.
- `parity_error`  out  1  sticky; set on a parity mismatch.

## Operation
- Reset: all outputs 0, `params` all zero, state IDLE, counter 0, all synchroniser flops 0.
- `sen` and `lreq` are the synchronised versions of `system_enable` and `load_params`. `lrise` is `lreq` AND NOT (`lreq` delayed by one flop).
- A bit is accepted in a cycle when state is SHIFT or PARITY, `sen`=1, and `serial_valid`=1.
- IDLE: on `lrise` with `sen`=1, go to SHIFT. Clear the counter, the shadow register, and `parity_error`. An `lrise` with `sen`=0 is ignored.
- SHIFT: on each accepted bit, `shadow <= {shadow[TOTAL_BITS-2:0], serial_in}` and increment the counter. After the bit at index TOTAL_BITS-1 is accepted:
  - PARITY_EN=1: go to PARITY.
  - PARITY_EN=0: commit and go to IDLE.
- PARITY: on the accepted bit, compute XOR of the shadow register and the bit.
  - Result 0: commit and go to IDLE.
  - Result 1: set `parity_error`, leave `params` and `params_valid` unchanged, go to IDLE.
- Commit: `params <= final shadow` (including the bit accepted that cycle), set `params_valid`, pulse `end_writing`.
- `sen`=0 in SHIFT or PARITY: stall. No bits are accepted, and the counter and shadow hold.
- `lrise` in SHIFT or PARITY: abort and restart the load from bit 0. `params` is untouched.
- `serial_valid` outside SHIFT and PARITY is ignored.
- Counter width is `$clog2(TOTAL_BITS+1)`. The counter never wraps: the FSM leaves SHIFT at TOTAL_BITS-1.
- `reset` mid-load returns everything to reset values, including `params`.

## Timing
- `load_params` first sampled high at edge k: `lreq` is high after edge k+SYNC_STAGES-1 and `lrise` is high in the following cycle. The state is SHIFT and `busy`=1 after edge k+SYNC_STAGES. The first bit can be accepted at edge k+SYNC_STAGES+1.
- `system_enable` takes effect SYNC_STAGES cycles after it is sampled.
- `data_written` is registered: high for exactly the one cycle after each accepting edge.
- `params`, `params_valid`, and `end_writing` update on the same edge that accepts the final bit. `end_writing` is high for that one cycle only. `busy` falls on that edge.
- Best-case load time with continuous `serial_valid` and `sen`=1: SYNC_STAGES+1+TOTAL_BITS+PARITY_EN cycles from the first sample of `load_params`.
- `parity_error` is set on the edge that accepts the parity bit and stays set until the next load start or `reset`.

## Structure
- Shared package `rsnn_pkg` holds:
  - `RSNN_PARAM_BITS`=312, `RSNN_WEIGHT_BITS`=216, `RSNN_NEURON_PARAM_BITS`=96, `RSNN_WEIGHT_LSB`=96.
  - The loader state enum `{IDLE, SHIFT, PARITY}`.
- Sub-module `rsnn_sync_chain`, parameter `STAGES`: an asynchronous-reset, reset-to-0 flop chain. Instantiate it once for `system_enable` and once for `load_params`.

## Test plan
1. TOTAL_BITS=8, PARITY_EN=0: pulse `load_params`, then shift 1,0,1,1,0,0,1,0 with `serial_valid` held high.
   -> `params`=8'hB2, `params_valid`=1, 8 `data_written` pulses, one `end_writing` pulse on the edge accepting the 8th bit.
2. PARITY_EN=1: shift 8'hB2 then parity bit 0 -> commit, `params`=8'hB2. Reload with 8'h00 and parity bit 1 -> `parity_error`=1, `params` stays 8'hB2, no `end_writing` pulse.
3. Drop `system_enable` for 5 cycles after bit 3, and toggle `serial_valid` randomly throughout.
   -> Stall during the low window, no extra bits accepted, final `params` matches the stream.
4. Raise `load_params` again after bit 4 of 8'hFF, then send 8'h3C.
   -> Load restarts from bit 0, `params`=8'h3C, old `params` held until that commit.
5. Assert `reset` mid-load, after bit 5.
   -> All outputs 0 immediately. A subsequent full load succeeds.
6. Default configuration (312 bits, random stream, correct parity).
   -> `params[311:96]` and `params[95:0]` match the stream. Commit occurs 2+1+313 cycles after `load_params` is first sampled.
